wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two sources:
  - the single-cycle pipeline writeback;
  - a long-latency unit (multiply/divide, multi-cycle load) that returns results out of band.
- Buffers long-latency results in a small FIFO and drains them into idle write-port cycles.
- Keeps a per-register busy scoreboard and raises a decode stall for RAW/WAW hazards on outstanding destinations.
- Sits between control/writeback and the register file write port.

Parameters:
DATA_WIDTH, 32, register/data width
ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)
QDEPTH, 2, long-latency result FIFO depth (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
pipe_we  input  1  pipeline writeback valid this cycle
pipe_rd  input  ADDR_WIDTH  pipeline destination register
pipe_data  input  DATA_WIDTH  pipeline writeback data
mc_issue  input  1  long-latency op issued this cycle (upstream qualifies with !stall)
mc_issue_rd  input  ADDR_WIDTH  destination of issued long-latency op
mc_valid  input  1  long-latency result offered
mc_rd  input  ADDR_WIDTH  result destination
mc_data  input  DATA_WIDTH  result data
mc_ready  output  1  FIFO can accept a result
dec_rs1  input  ADDR_WIDTH  decode source 1
dec_rs2  input  ADDR_WIDTH  decode source 2
dec_rd  input  ADDR_WIDTH  decode destination
dec_we  input  1  decoded instruction writes dec_rd
stall  output  1  hold fetch/decode this cycle
rf_we  output  1  register file write enable
rf_waddr  output  ADDR_WIDTH  register file write address
rf_wdata  output  DATA_WIDTH  register file write data
pend_cnt  output  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
Reset (rst=0, asynchronous):
- FIFO emptied; scoreboard cleared.
- rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, mc_ready=0, pend_cnt=0, all forced while rst=0.
- Reset asserted mid-drain discards all queued results.
- mc_ready=1 from the first cycle after release.

Write port (combinational, zero latency):
- A write is "live" only if its destination != 0.
- Pipeline has fixed priority. If pipe_we && pipe_rd!=0: rf_we=1, rf_waddr=pipe_rd, rf_wdata=pipe_data.
- Else, if FIFO not empty: drive the FIFO head with rf_we=1, and the head pops at the clock edge.
- Else rf_we=0, with waddr/wdata held at 0.
- A pipeline write with pipe_rd=0 never drives the port and leaves the slot free for a drain.

FIFO:
- mc_ready = !full, from registered occupancy only; a same-cycle drain does not raise it.
- Accept on mc_valid && mc_ready at the edge. The result is drainable from the next cycle, so minimum accept-to-write latency is 1 cycle.
- Results with mc_rd=0 are accepted and discarded: not enqueued, no scoreboard effect.
- Simultaneous accept and drain keep occupancy unchanged.
- Drain order is strictly FIFO.
- Pointers wrap modulo QDEPTH.
- A full FIFO with a continuously busy pipeline holds mc_ready=0 indefinitely. This is legal; the long-latency unit holds its result.

Scoreboard:
- One busy bit per register; bit 0 is permanently 0.
- Set at the edge when mc_issue && mc_issue_rd!=0.
- Cleared at the edge when that register is written by a FIFO drain.
- Set and clear of the same register in one cycle: set wins.

Stall (combinational from scoreboard state):
stall = (busy[dec_rs1]) | (busy[dec_rs2]) | (dec_we & busy[dec_rd]).
- Stall deasserts the cycle after the clearing drain; no bypass from the FIFO.
- A pipeline write to a busy register (upstream bug) is performed. It does not alter busy, and ordering is by write cycle.

Test Plan:
- Reset: hold rst=0 with pipe_we=1, pipe_rd=4 -> rf_we=0, stall=0, mc_ready=0, pend_cnt=0. Release -> mc_ready=1 next cycle and rf_we=1, waddr=4.
- RAW stall: mc_issue rd=5; next cycle dec_rs1=5 -> stall=1. mc_valid rd=5 data=0xDEADBEEF with pipe idle -> the following cycle rf_we=1, waddr=5, wdata=0xDEADBEEF. Stall=0 one cycle later.
- Priority and backpressure: pipe_we=1, rd=3 every cycle while mc offers rd=6 (0x11) then rd=7 (0x22):
  - port always shows rd=3;
  - pend_cnt=2 and mc_ready=0;
  - drop pipe_we -> writes x6=0x11 then x7=0x22 on consecutive cycles, pend_cnt 2->1->0.
- x0 handling: pipe_we rd=0, mc rd=0, mc_issue rd=0, dec_rs1=0 -> no rf write, pend_cnt unchanged, no stall.
- Full-boundary: FIFO full, pipe idle -> one drain per cycle. mc_ready=1 only in the cycle after pend_cnt drops to 1. Simultaneous accept and drain keep pend_cnt=1.
- WAW and reset mid-operation: busy x9 -> dec_we=1, dec_rd=9 gives stall=1. Assert rst with 2 entries queued -> rf_we=0 immediately, pend_cnt=0, busy cleared (stall=0 after release).

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a small FIFO and drain into idle slots, with a busy scoreboard for decode.
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int QDEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [ADDR_WIDTH-1:0]      pipe_rd,
    input  logic [DATA_WIDTH-1:0]      pipe_data,
    input  logic                       mc_issue,
    input  logic [ADDR_WIDTH-1:0]      mc_issue_rd,
    input  logic                       mc_valid,
    input  logic [ADDR_WIDTH-1:0]      mc_rd,
    input  logic [DATA_WIDTH-1:0]      mc_data,
    output logic                       mc_ready,
    input  logic [ADDR_WIDTH-1:0]      dec_rs1,
    input  logic [ADDR_WIDTH-1:0]      dec_rs2,
    input  logic [ADDR_WIDTH-1:0]      dec_rd,
    input  logic                       dec_we,
    output logic                       stall,
    output logic                       rf_we,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [$clog2(QDEPTH):0]    pend_cnt
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW   = $clog2(QDEPTH) + 1;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;
    logic [DATA_WIDTH-1:0] q_data [QDEPTH];
    logic [ADDR_WIDTH-1:0] q_rd   [QDEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  pipe_live;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  do_drain;
    logic                  do_enq;

    assign pipe_live  = pipe_we && (pipe_rd != '0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(QDEPTH));
    assign do_drain   = rst && !pipe_live && !fifo_empty;
    // Ready comes from registered occupancy only, so a drain this cycle cannot raise it.
    assign mc_ready   = rst && !fifo_full;
    assign do_enq     = mc_valid && mc_ready && (mc_rd != '0);
    assign pend_cnt   = count;
    assign stall      = rst && (busy[dec_rs1] || busy[dec_rs2] || (dec_we && busy[dec_rd]));

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pipe_live && rst) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
        end else if (do_drain) begin
            rf_we    = 1'b1;
            rf_waddr = q_rd[rd_ptr];
            rf_wdata = q_data[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_drain)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_enq) - CW'(do_drain);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            q_data[wr_ptr] <= mc_data;
            q_rd[wr_ptr]   <= mc_rd;
        end
    end

    // A new issue to the register being drained keeps it busy, so set is applied last.
    always_comb begin
        busy_next = busy;
        if (do_drain)
            busy_next[q_rd[rd_ptr]] = 1'b0;
        if (mc_issue)
            busy_next[mc_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the write-port rules.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int QD = 2;

    logic          clk;
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          mc_issue;
    logic [AW-1:0] mc_issue_rd;
    logic          mc_valid;
    logic [AW-1:0] mc_rd;
    logic [DW-1:0] mc_data;
    logic          mc_ready;
    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic [AW-1:0] dec_rd;
    logic          dec_we;
    logic          stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [$clog2(QD):0] pend_cnt;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    bit   mbusy[32];
    int   checks = 0;
    int   errors = 0;

    wb_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
    endtask

    task automatic checkOutput(input string tag);
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          er;
        logic          es;
        int            sz;
        sz  = mq.size();
        ewe = 1'b0; ea = '0; ed = '0; er = 1'b0; es = 1'b0;
        if (rst) begin
            er = (sz < QD);
            es = mbusy[dec_rs1] || mbusy[dec_rs2] || (dec_we && mbusy[dec_rd]);
            if (pipe_we && pipe_rd != 0) begin
                ewe = 1'b1; ea = pipe_rd; ed = pipe_data;
            end else if (sz > 0) begin
                ewe = 1'b1; ea = mq[0].rd; ed = mq[0].data;
            end
        end else begin
            sz = 0;
        end
        cmp({tag, ".rf_we"},    32'(rf_we),    32'(ewe));
        cmp({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(ea));
        cmp({tag, ".rf_wdata"}, rf_wdata,      ed);
        cmp({tag, ".mc_ready"}, 32'(mc_ready), 32'(er));
        cmp({tag, ".stall"},    32'(stall),    32'(es));
        cmp({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(sz));
    endtask

    task automatic modelUpdate();
        int   sz;
        bit   live;
        ent_t e;
        sz   = mq.size();
        live = pipe_we && (pipe_rd != 0);
        if (!live && sz > 0) begin
            e = mq.pop_front();
            mbusy[e.rd] = 0;
        end
        if (mc_valid && (sz < QD) && mc_rd != 0) begin
            e.rd = mc_rd;
            e.data = mc_data;
            mq.push_back(e);
        end
        if (mc_issue && mc_issue_rd != 0)
            mbusy[mc_issue_rd] = 1;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic applyStimulus(input string tag);
        #2;
        checkOutput(tag);
        @(posedge clk);
        if (rst)
            modelUpdate();
        else
            modelReset();
        @(negedge clk);
    endtask

    task automatic idle();
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        mc_issue = 0; mc_issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_we = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        modelReset();
        @(negedge clk);

        pipe_we = 1; pipe_rd = 4; pipe_data = 32'h44;
        applyStimulus("reset_a");
        applyStimulus("reset_b");
        #2;
        cmp("reset.rf_we", 32'(rf_we), 0);
        cmp("reset.mc_ready", 32'(mc_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        cmp("release.waddr", 32'(rf_waddr), 4);
        cmp("release.mc_ready", 32'(mc_ready), 1);
        applyStimulus("release");

        idle();
        mc_issue = 1; mc_issue_rd = 5;
        applyStimulus("raw_issue");
        mc_issue = 0; dec_rs1 = 5;
        #2;
        cmp("raw.stall", 32'(stall), 1);
        applyStimulus("raw_stall");
        mc_valid = 1; mc_rd = 5; mc_data = 32'hDEADBEEF;
        applyStimulus("raw_accept");
        mc_valid = 0;
        #2;
        cmp("raw.drain_addr", 32'(rf_waddr), 5);
        cmp("raw.drain_data", rf_wdata, 32'hDEADBEEF);
        cmp("raw.stall_hold", 32'(stall), 1);
        applyStimulus("raw_drain");
        #2;
        cmp("raw.stall_clear", 32'(stall), 0);
        applyStimulus("raw_clear");

        idle();
        pipe_we = 1; pipe_rd = 3; pipe_data = 32'h33;
        mc_valid = 1; mc_rd = 6; mc_data = 32'h11;
        applyStimulus("prio_a");
        mc_rd = 7; mc_data = 32'h22;
        applyStimulus("prio_b");
        mc_rd = 8; mc_data = 32'h88;
        #2;
        cmp("prio.pend", 32'(pend_cnt), 2);
        cmp("prio.ready", 32'(mc_ready), 0);
        cmp("prio.addr", 32'(rf_waddr), 3);
        applyStimulus("prio_c");
        idle();
        #2;
        cmp("prio.drain6", rf_wdata, 32'h11);
        applyStimulus("prio_d");
        #2;
        cmp("prio.drain7", rf_wdata, 32'h22);
        applyStimulus("prio_e");
        applyStimulus("prio_f");

        pipe_we = 1; pipe_rd = 0; pipe_data = 32'h99;
        mc_valid = 1; mc_rd = 0; mc_data = 32'h77;
        mc_issue = 1; mc_issue_rd = 0;
        applyStimulus("x0_a");
        idle();
        #2;
        cmp("x0.pend", 32'(pend_cnt), 0);
        cmp("x0.rf_we", 32'(rf_we), 0);
        applyStimulus("x0_b");

        pipe_we = 1; pipe_rd = 3; pipe_data = 32'h5;
        mc_valid = 1; mc_rd = 10; mc_data = 32'hA0;
        applyStimulus("full_a");
        mc_rd = 11; mc_data = 32'hB0;
        applyStimulus("full_b");
        pipe_we = 0; mc_rd = 12; mc_data = 32'hC0;
        applyStimulus("full_c");
        #2;
        cmp("full.ready_at_one", 32'(mc_ready), 1);
        applyStimulus("full_d");
        #2;
        cmp("full.pend_held", 32'(pend_cnt), 1);
        mc_valid = 0;
        applyStimulus("full_e");
        applyStimulus("full_f");

        idle();
        mc_issue = 1; mc_issue_rd = 9;
        applyStimulus("waw_issue");
        mc_issue = 0; dec_we = 1; dec_rd = 9;
        pipe_we = 1; pipe_rd = 2; pipe_data = 32'h2;
        mc_valid = 1; mc_rd = 13; mc_data = 32'hD0;
        #2;
        cmp("waw.stall", 32'(stall), 1);
        applyStimulus("waw_a");
        mc_rd = 14; mc_data = 32'hE0;
        applyStimulus("waw_b");
        mc_valid = 0; pipe_we = 0;
        #1;
        rst = 1'b0;
        #1;
        cmp("midrst.rf_we", 32'(rf_we), 0);
        cmp("midrst.pend", 32'(pend_cnt), 0);
        modelReset();
        @(negedge clk);
        applyStimulus("midrst_hold");
        rst = 1'b1;
        #2;
        cmp("midrst.stall", 32'(stall), 0);
        applyStimulus("midrst_release");

        for (int i = 0; i < 400; i++) begin
            pipe_we     = ($urandom_range(0, 3) != 0);
            pipe_rd     = AW'($urandom_range(0, 7));
            pipe_data   = $urandom;
            mc_issue    = ($urandom_range(0, 3) == 0);
            mc_issue_rd = AW'($urandom_range(0, 7));
            mc_valid    = ($urandom_range(0, 1) == 1);
            mc_rd       = AW'($urandom_range(0, 7));
            mc_data     = $urandom;
            dec_rs1     = AW'($urandom_range(0, 7));
            dec_rs2     = AW'($urandom_range(0, 7));
            dec_rd      = AW'($urandom_range(0, 7));
            dec_we      = ($urandom_range(0, 1) == 1);
            applyStimulus("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
